// File: rtl/estimador_pkg.sv
// Shared definitions for the estimator block-level initiators.
package estimador_pkg;

  // Default element width (signed fixed point, two's complement).
  localparam int unsigned W_DEFAULT = 21;

  // Elements per row vector.
  localparam int unsigned NELEM = 3;

  // Default watchdog budget, in RUN cycles.
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // Initiator handshake states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/estimador_watchdog.sv
// Cycle watchdog: counts enabled cycles after a clear and flags the cycle in
// which the 1-based cycle count equals LIMIT. The count saturates there.
module estimador_watchdog #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned CW    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  // count_q holds the number of enabled cycles already elapsed, so the
  // current cycle is number count_q + 1.
  localparam logic [CW-1:0] LastCount = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;

  assign expired = en && (count_q == LastCount);

  // Elapsed-cycle counter; holds once the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en && !expired) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/estimador_vadd_row_master.sv
// ap_ctrl_hs initiator for the vadd_row callee: latches an operand pair,
// starts the callee, gathers the per-element results on their vld strobes
// and presents the assembled vector with an error flag.
module estimador_vadd_row_master
  import estimador_pkg::*;
#(
  parameter int unsigned W       = W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NELEM*W-1:0]   in_a,
  input  logic [NELEM*W-1:0]   in_b,
  output logic                 vadd_start,
  input  logic                 vadd_done,
  input  logic                 vadd_ready,
  input  logic                 vadd_idle,
  output logic [NELEM*W-1:0]   vadd_a,
  output logic [NELEM*W-1:0]   vadd_b,
  input  logic [NELEM*W-1:0]   vadd_y,
  input  logic [NELEM-1:0]     vadd_y_vld,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NELEM*W-1:0]   out_y,
  output logic                 out_err,
  output logic [15:0]          run_count
);

  localparam int unsigned WdW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e           state_q;
  logic [NELEM-1:0] mask_q;
  logic [NELEM-1:0] mask_all;
  logic             wd_clear;
  logic             wd_en;
  logic             wd_expired;
  logic             unused_status;

  // Callee status lines are informational only.
  assign unused_status = vadd_ready ^ vadd_idle;

  // Held low while reset is asserted, high from the first cycle after release.
  assign in_ready = ap_rst_n && (state_q == StIdle);

  // Capture mask including strobes arriving this cycle.
  assign mask_all = mask_q | vadd_y_vld;

  assign wd_en    = (state_q == StRun);
  assign wd_clear = (state_q != StRun);

  estimador_watchdog #(
    .LIMIT (TIMEOUT),
    .CW    (WdW)
  ) u_watchdog (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .clear   (wd_clear),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Handshake FSM with registered outputs and result capture.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StIdle;
      vadd_start <= 1'b0;
      vadd_a     <= '0;
      vadd_b     <= '0;
      mask_q     <= '0;
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_err    <= 1'b0;
      run_count  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            vadd_a     <= in_a;
            vadd_b     <= in_b;
            mask_q     <= '0;
            out_y      <= '0;
            out_err    <= 1'b0;
            vadd_start <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          // Last strobe for an element wins.
          for (int k = 0; k < NELEM; k++) begin
            if (vadd_y_vld[k]) begin
              out_y[k*W +: W] <= vadd_y[k*W +: W];
            end
          end
          mask_q <= mask_all;
          // A done in the expiry cycle takes priority over the watchdog.
          if (vadd_done) begin
            out_err    <= ~&mask_all;
            run_count  <= run_count + 16'd1;
            vadd_start <= 1'b0;
            out_valid  <= 1'b1;
            state_q    <= StHold;
          end else if (wd_expired) begin
            out_err    <= 1'b1;
            vadd_start <= 1'b0;
            out_valid  <= 1'b1;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_estimador_vadd_row_master.sv
// Bench for estimador_vadd_row_master: table of operand/expected records plus
// random records scored by a plain-arithmetic model, a behavioural callee
// driven cycle by cycle, and a hand-written reset-during-RUN sequence.
module tb_estimador_vadd_row_master;

  localparam int W    = 21;
  localparam int N    = 3;
  localparam int TMO  = 16;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic           ap_clk;
  logic           ap_rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic           vadd_start;
  logic           vadd_done;
  logic           vadd_ready;
  logic           vadd_idle;
  logic [N*W-1:0] vadd_a;
  logic [N*W-1:0] vadd_b;
  logic [N*W-1:0] vadd_y;
  logic [N-1:0]   vadd_y_vld;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_y;
  logic           out_err;
  logic [15:0]    run_count;

  estimador_vadd_row_master #(
    .W       (W),
    .TIMEOUT (TMO)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .vadd_start (vadd_start),
    .vadd_done  (vadd_done),
    .vadd_ready (vadd_ready),
    .vadd_idle  (vadd_idle),
    .vadd_a     (vadd_a),
    .vadd_b     (vadd_b),
    .vadd_y     (vadd_y),
    .vadd_y_vld (vadd_y_vld),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_err    (out_err),
    .run_count  (run_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N-1:0]   vld;
    logic           done;
    logic [3:0]     hold;
    logic [N*W-1:0] exp_y;
    logic           exp_err;
  } vec_t;

  int   n_tests;
  int   n_fail;
  int   model_runs;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic int clamp(input int s);
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  function automatic int elem(input logic [N*W-1:0] v, input int k);
    logic signed [W-1:0] e;
    e = v[k*W +: W];
    return int'(e);
  endfunction

  function automatic logic [N*W-1:0] pack3(input int x0, input int x1, input int x2);
    logic [N*W-1:0] r;
    r[0 +: W]   = x0[W-1:0];
    r[W +: W]   = x1[W-1:0];
    r[2*W +: W] = x2[W-1:0];
    return r;
  endfunction

  function automatic logic [N*W-1:0] rnd_vec();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[N*W-1:0];
  endfunction

  function automatic int rnd_elem();
    return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
  endfunction

  // Reference: delivered elements carry the saturated sum, missing ones stay
  // zero; error if anything is missing or the callee never finished.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   y[N];
    r = v;
    for (int k = 0; k < N; k++) begin
      y[k] = v.vld[k] ? clamp(elem(v.a, k) + elem(v.b, k)) : 0;
    end
    r.exp_y   = pack3(y[0], y[1], y[2]);
    r.exp_err = !v.done || (v.vld != 3'b111);
    return r;
  endfunction

  // One full transaction with the behavioural callee answering from its ports.
  task automatic run_txn(input vec_t v);
    logic [N*W-1:0] yv;
    bit             ok;
    int             s;
    check("idle_in_ready", in_ready, 1);
    in_a     = v.a;
    in_b     = v.b;
    in_valid = 1'b1;
    // Stray callee activity while idle must be ignored.
    vadd_y     = rnd_vec();
    vadd_y_vld = 3'b111;
    vadd_done  = 1'b1;
    step();
    in_valid   = 1'b0;
    in_a       = rnd_vec();
    in_b       = rnd_vec();
    vadd_y_vld = '0;
    vadd_done  = 1'b0;
    check("start_t1", vadd_start, 1);
    check("busy_in_ready", in_ready, 0);
    check("vadd_a", vadd_a, v.a);
    check("vadd_b", vadd_b, v.b);
    check("count_idle_done", run_count, model_runs);
    for (int j = 0; j < N; j++) begin
      step();
      yv = rnd_vec();
      s  = clamp(elem(vadd_a, j) + elem(vadd_b, j));
      yv[j*W +: W] = s[W-1:0];
      vadd_y     = yv;
      vadd_y_vld = v.vld[j] ? (3'b001 << j) : 3'b000;
      vadd_done  = v.done && (j == N - 1);
    end
    check("no_valid_t4", out_valid, 0);
    check("frozen_a_t4", vadd_a, v.a);
    step();
    vadd_y_vld = '0;
    vadd_done  = 1'b0;
    if (!v.done) begin
      ok = 1'b1;
      for (int c = 5; c <= TMO; c++) begin
        if (out_valid !== 1'b0) ok = 1'b0;
        step();
      end
      check("no_early_timeout", ok, 1);
    end
    check("out_valid", out_valid, 1);
    check("start_dropped", vadd_start, 0);
    if (v.done) model_runs = (model_runs + 1) & 16'hffff;
    check("out_y", out_y, v.exp_y);
    check("out_err", out_err, v.exp_err);
    check("run_count", run_count, model_runs);
    out_ready = 1'b0;
    ok = 1'b1;
    for (int h = 0; h < int'(v.hold); h++) begin
      vadd_y     = rnd_vec();
      vadd_y_vld = 3'($urandom);
      vadd_done  = 1'($urandom);
      step();
      if (out_y !== v.exp_y || out_err !== v.exp_err || out_valid !== 1'b1 ||
          in_ready !== 1'b0 || vadd_start !== 1'b0 || run_count !== model_runs[15:0]) ok = 1'b0;
    end
    if (v.hold != 0) check("hold_stable", ok, 1);
    vadd_y_vld = '0;
    vadd_done  = 1'b0;
    out_ready  = 1'b1;
    step();
    out_ready = 1'b0;
    check("released_valid", out_valid, 0);
    check("released_ready", in_ready, 1);
  endtask

  initial begin
    vec_t v;
    n_tests    = 0;
    n_fail     = 0;
    model_runs = 0;
    ap_rst_n   = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    vadd_done  = 1'b0;
    vadd_ready = 1'b1;
    vadd_idle  = 1'b1;
    vadd_y     = '0;
    vadd_y_vld = '0;
    out_ready  = 1'b0;

    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_count", run_count, 0);
    step();
    step();
    ap_rst_n = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_start", vadd_start, 0);
    check("post_rst_y", out_y, 0);

    // Directed records: {a, b, delivered mask, done, hold, expected y, err}.
    tbl.push_back('{pack3(1, 2, 3), pack3(10, 20, 30), 3'b111, 1'b1, 4'd0,
                    pack3(11, 22, 33), 1'b0});
    tbl.push_back('{pack3(1048575, -1048576, 5), pack3(1, -1, -7), 3'b111, 1'b1, 4'd1,
                    pack3(1048575, -1048576, -2), 1'b0});
    tbl.push_back('{pack3(4, 5, 6), pack3(-1, -2, -3), 3'b111, 1'b1, 4'd10,
                    pack3(3, 3, 3), 1'b0});
    tbl.push_back('{pack3(100, -200, 300), pack3(1, 2, 3), 3'b101, 1'b1, 4'd0,
                    pack3(101, 0, 303), 1'b1});
    tbl.push_back('{pack3(7, 8, 9), pack3(1, 1, 1), 3'b111, 1'b0, 4'd2,
                    pack3(8, 9, 10), 1'b1});
    for (int i = 0; i < 16; i++) begin
      v.a    = pack3(rnd_elem(), rnd_elem(), rnd_elem());
      v.b    = pack3(rnd_elem(), rnd_elem(), rnd_elem());
      v.vld  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      v.done = ($urandom_range(0, 4) != 0);
      v.hold = 4'($urandom_range(0, 3));
      tbl.push_back(model(v));
    end
    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset in the second RUN cycle, with one element already captured.
    in_a     = pack3(9, 9, 9);
    in_b     = pack3(1, 1, 1);
    in_valid = 1'b1;
    step();
    in_valid   = 1'b0;
    vadd_y     = pack3(10, 10, 10);
    vadd_y_vld = 3'b001;
    step();
    vadd_y_vld = '0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_start", vadd_start, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_err", out_err, 0);
    check("mid_rst_y", out_y, 0);
    check("mid_rst_a", vadd_a, 0);
    check("mid_rst_b", vadd_b, 0);
    check("mid_rst_count", run_count, 0);
    model_runs = 0;
    step();
    step();
    ap_rst_n = 1'b1;
    #1;
    check("mid_rst_release", in_ready, 1);
    v.a    = pack3(-5, 0, 70000);
    v.b    = pack3(2, 0, -1);
    v.vld  = 3'b111;
    v.done = 1'b1;
    v.hold = 4'd0;
    run_txn(model(v));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/estimador_vadd_row_master.md
# estimador_vadd_row_master

Initiator side of the `ap_ctrl_hs` block-level handshake used by the estimator's generated vector-add row loop (3 elements, W-bit signed fixed point, saturating). The block accepts operand vectors over a valid/ready stream and holds them stable on the callee's scalar operand ports. It pulses `vadd_start` and collects the three per-element results on their `_ap_vld` strobes. It then presents the assembled result vector downstream with an error flag. It sits between the estimator datapath sequencer and the `vadd_row` pipeline instance.

## Interface
- `W`, 21: element width (signed, two's complement)
- `TIMEOUT`, 16: cycles allowed from first `vadd_start` to `vadd_done` before abort
- `ap_clk`  in  1  clock, rising edge
- `ap_rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  operand vectors valid
- `in_ready`  out  1  block can accept operands
- `in_a`  in  3*W  element k at `[k*W +: W]`
- `in_b`  in  3*W  element k at `[k*W +: W]`
- `vadd_start`  out  1  callee `ap_start`
- `vadd_done`, `vadd_ready`, `vadd_idle`  in  1 each  callee status
- `vadd_a`, `vadd_b`  out  3*W  operands to the callee reload ports
- `vadd_y`  in  3*W  callee per-element outputs
- `vadd_y_vld`  in  3  per-element `_ap_vld`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `out_y`  out  3*W  result vector
- `out_err`  out  1  missing element or timeout
- `run_count`  out  16  completed transactions (wraps 0xFFFF→0)

## Operation
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid`, register `in_a`/`in_b` into `vadd_a`/`vadd_b`, clear capture mask and `out_y` to 0, then go to RUN.
  - RUN: `vadd_start=1`, `in_ready=0`. Operand registers are frozen. Each cycle, for each k with `vadd_y_vld[k]`, load `out_y[k]` from `vadd_y[k]` and set `mask[k]`.
    - On `vadd_done`, go to HOLD; `out_err` = NOT(all three mask bits set, counting same-cycle strobes). `run_count` increments.
    - When the watchdog reaches `TIMEOUT`, go to HOLD with `out_err=1`; `out_y` keeps whatever was captured and `run_count` is unchanged.
  - HOLD: `out_valid=1`, `vadd_start=0`. On `out_ready`, go to IDLE.
- `vadd_idle` and `vadd_ready` are not used for control. A `vadd_done` received outside RUN is ignored.
- Vld strobes outside RUN are ignored. A repeated strobe for the same element in RUN overwrites that element (last value wins).
- Data passes through unchanged; saturation is performed by the callee.

## Timing
- Reset values: `in_ready=0` while reset is asserted; IDLE after release, so `in_ready=1` the first cycle after reset. `vadd_start=0`, `out_valid=0`, `out_err=0`, `out_y=0`, `vadd_a=vadd_b=0`, `run_count=0`, watchdog 0.
- Accept at cycle T (`in_valid & in_ready`), then `vadd_start=1` from T+1.
- With the 3-iteration callee, `vadd_done` arrives at T+4 and `out_valid` is asserted at T+5. `vadd_start` drops at T+5.
- The watchdog counts RUN cycles starting at 1. If it reaches `TIMEOUT` with no `vadd_done`, `out_valid` is asserted at T+1+`TIMEOUT`.
- `vadd_done` and watchdog expiry in the same cycle: `vadd_done` wins.
- `out_y`/`out_err` are stable while `out_valid & !out_ready`. There is no accept in the HOLD→IDLE cycle, so at most one transaction is accepted every 6 cycles.
- Reset mid-RUN: outputs return to reset values asynchronously; the callee sees `vadd_start` fall.

## Structure
- Shared package `estimador_pkg`: `W` default, `NELEM=3`, FSM state enum, the `TIMEOUT` default.
- One sub-module, `estimador_watchdog`: a parameterised cycle counter with `clear`, `en` and `expired`. It is reusable by the other estimator initiators.
- The `vadd_row` instance is not included in this block. The bench supplies a behavioural callee.

## Test plan
- Nominal: a=(1,2,3), b=(10,20,30) → `out_y`=(11,22,33), `out_err=0`, `out_valid` at T+5, `run_count`=1.
- Saturation pass-through: a0=1048575, b0=1; a1=−1048576, b1=−1 → y0=1048575, y1=−1048576, `out_err=0`.
- Backpressure: `out_ready=0` for 10 cycles → `out_y` stable, `in_ready=0`, `vadd_start=0`; accept on release, then a new transaction starts the next cycle.
- Missing strobe: callee never asserts `vadd_y_vld[1]` → `out_err=1`, y1=0, y0/y2 correct.
- Timeout: callee never asserts `vadd_done` → `out_valid` at T+17 with `out_err=1`, `run_count` unchanged.
- Reset during RUN (T+2): all outputs at reset values within the cycle; after release, a nominal transaction completes correctly.
